// File: rtl/axi_read_arbiter.sv
// AXI read-channel arbiter for a 2-master / 2-slave interconnect: round-robin AR grant,
// address decode to S0/S1/default slave, grant held until RLAST. Watchdog under AXI_ARB_TIMEOUT_EN.
module axi_read_arbiter #(
  parameter logic [31:0] S0_BASE     = 32'h0000_0000,
  parameter logic [31:0] S1_BASE     = 32'h0001_0000,
  parameter logic [31:0] REGION_SIZE = 32'h0001_0000,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arvalid_m0,
  input  logic [31:0] araddr_m0,
  input  logic [3:0]  arlen_m0,
  input  logic        arvalid_m1,
  input  logic [31:0] araddr_m1,
  input  logic [3:0]  arlen_m1,
  output logic        arready_m0,
  output logic        arready_m1,
  output logic        arvalid_s0,
  output logic        arvalid_s1,
  input  logic        arready_s0,
  input  logic        arready_s1,
  input  logic        rvalid_s0,
  input  logic        rlast_s0,
  input  logic        rvalid_s1,
  input  logic        rlast_s1,
  input  logic        rready_m0,
  input  logic        rready_m1,
  output logic [1:0]  grant,
  output logic [2:0]  sel,
  output logic        dflt_rvalid,
  output logic        dflt_rlast,
  output logic        busy,
  output logic        timeout
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, DFLT_ADDR, DFLT_DATA} state_t;

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [2:0]  sel_q, sel_d;
  logic        rr_last_q, rr_last_d;   // 1 = M1 was served last
  logic [3:0]  beat_q, beat_d;

  logic        pick_m1;
  logic [31:0] pick_addr;
  logic        g_arvalid, g_rready;
  logic        s_arready, s_rvalid, s_rlast;
  logic        wd_expired;

  function automatic logic in_region(input logic [31:0] addr, input logic [31:0] base);
    return (addr >= base) && ((addr - base) < REGION_SIZE);
  endfunction

  // On a tie the master that was not served last wins.
  assign pick_m1   = arvalid_m1 & (~arvalid_m0 | ~rr_last_q);
  assign pick_addr = pick_m1 ? araddr_m1 : araddr_m0;

  assign g_arvalid = grant_q[1] ? arvalid_m1 : arvalid_m0;
  assign g_rready  = grant_q[1] ? rready_m1  : rready_m0;
  assign s_arready = sel_q[1] ? arready_s1 : arready_s0;
  assign s_rvalid  = sel_q[1] ? rvalid_s1  : rvalid_s0;
  assign s_rlast   = sel_q[1] ? rlast_s1   : rlast_s0;

`ifdef AXI_ARB_TIMEOUT_EN
  logic [15:0] wd_q;

  always_ff @(posedge clk) begin
    if (rst || state_q != DATA || (s_rvalid && g_rready)) wd_q <= '0;
    else                                                  wd_q <= wd_q + 16'd1;
  end

  assign wd_expired = (wd_q == 16'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      sel_q     <= '0;
      rr_last_q <= 1'b1;
      beat_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      rr_last_q <= rr_last_d;
      beat_q    <= beat_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    sel_d       = sel_q;
    rr_last_d   = rr_last_q;
    beat_d      = beat_q;
    arready_m0  = 1'b0;
    arready_m1  = 1'b0;
    arvalid_s0  = 1'b0;
    arvalid_s1  = 1'b0;
    dflt_rvalid = 1'b0;
    dflt_rlast  = 1'b0;
    timeout     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arvalid_m0 || arvalid_m1) begin
          grant_d = pick_m1 ? 2'b10 : 2'b01;
          if (in_region(pick_addr, S0_BASE)) begin
            sel_d   = 3'b001;
            state_d = ADDR;
          end else if (in_region(pick_addr, S1_BASE)) begin
            sel_d   = 3'b010;
            state_d = ADDR;
          end else begin
            sel_d   = 3'b100;
            state_d = DFLT_ADDR;
          end
        end
      end
      ADDR: begin
        arvalid_s0 = sel_q[0] & g_arvalid;
        arvalid_s1 = sel_q[1] & g_arvalid;
        arready_m0 = grant_q[0] & s_arready;
        arready_m1 = grant_q[1] & s_arready;
        if (g_arvalid && s_arready) state_d = DATA;
      end
      DATA: begin
        if ((s_rvalid && s_rlast && g_rready) || (wd_expired && !(s_rvalid && g_rready))) begin
          timeout   = ~(s_rvalid & s_rlast & g_rready);
          state_d   = IDLE;
          grant_d   = '0;
          sel_d     = '0;
          rr_last_d = grant_q[1];
        end
      end
      DFLT_ADDR: begin
        arready_m0 = grant_q[0];
        arready_m1 = grant_q[1];
        beat_d     = grant_q[1] ? arlen_m1 : arlen_m0;
        state_d    = DFLT_DATA;
      end
      DFLT_DATA: begin
        dflt_rvalid = 1'b1;
        dflt_rlast  = (beat_q == 4'd0);
        if (g_rready) begin
          if (beat_q == 4'd0) begin
            state_d   = IDLE;
            grant_d   = '0;
            sel_d     = '0;
            rr_last_d = grant_q[1];
          end else begin
            beat_d = beat_q - 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        sel_d   = '0;
      end
    endcase
  end

  assign grant = grant_q;
  assign sel   = sel_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: per-cycle vector table plus hand sequences
// for the 16-beat default burst and (with AXI_ARB_TIMEOUT_EN) the watchdog.
module tb_axi_read_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        arvalid_m0, arvalid_m1;
  logic [31:0] araddr_m0, araddr_m1;
  logic [3:0]  arlen_m0, arlen_m1;
  logic        arready_m0, arready_m1, arvalid_s0, arvalid_s1;
  logic        arready_s0, arready_s1;
  logic        rvalid_s0, rlast_s0, rvalid_s1, rlast_s1;
  logic        rready_m0, rready_m1;
  logic [1:0]  grant;
  logic [2:0]  sel;
  logic        dflt_rvalid, dflt_rlast, busy, timeout;

  int unsigned passed = 0;
  int unsigned total  = 0;

  always #5 clk = ~clk;

  axi_read_arbiter #(
    .S0_BASE    (32'h0000_0000),
    .S1_BASE    (32'h0001_0000),
    .REGION_SIZE(32'h0001_0000),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .rst(rst),
    .arvalid_m0(arvalid_m0), .araddr_m0(araddr_m0), .arlen_m0(arlen_m0),
    .arvalid_m1(arvalid_m1), .araddr_m1(araddr_m1), .arlen_m1(arlen_m1),
    .arready_m0(arready_m0), .arready_m1(arready_m1),
    .arvalid_s0(arvalid_s0), .arvalid_s1(arvalid_s1),
    .arready_s0(arready_s0), .arready_s1(arready_s1),
    .rvalid_s0(rvalid_s0), .rlast_s0(rlast_s0),
    .rvalid_s1(rvalid_s1), .rlast_s1(rlast_s1),
    .rready_m0(rready_m0), .rready_m1(rready_m1),
    .grant(grant), .sel(sel),
    .dflt_rvalid(dflt_rvalid), .dflt_rlast(dflt_rlast),
    .busy(busy), .timeout(timeout)
  );

  // Pair fields are {x1, x0}; exp = {ardy_m1,ardy_m0}_{arv_s1,arv_s0}_grant_sel_{drv,drl}_{busy,tmo}
  typedef struct {
    string       name;
    logic        rst;
    logic [1:0]  arv;
    logic [31:0] a0;
    logic [3:0]  l0;
    logic [31:0] a1;
    logic [3:0]  l1;
    logic [1:0]  sardy;
    logic [1:0]  srv;
    logic [1:0]  srl;
    logic [1:0]  rrdy;
    logic [12:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string nm, input logic r, input logic [1:0] arv,
                     input logic [31:0] a0, input logic [3:0] l0,
                     input logic [31:0] a1, input logic [3:0] l1,
                     input logic [1:0] sardy, input logic [1:0] srv,
                     input logic [1:0] srl, input logic [1:0] rrdy,
                     input logic [12:0] exp);
    vec_t v;
    v.name = nm; v.rst = r; v.arv = arv; v.a0 = a0; v.l0 = l0; v.a1 = a1; v.l1 = l1;
    v.sardy = sardy; v.srv = srv; v.srl = srl; v.rrdy = rrdy; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b required %b", nm, act, exp);
  endtask

  task automatic drive(input vec_t v);
    rst        = v.rst;
    arvalid_m0 = v.arv[0]; arvalid_m1 = v.arv[1];
    araddr_m0  = v.a0;     araddr_m1  = v.a1;
    arlen_m0   = v.l0;     arlen_m1   = v.l1;
    arready_s0 = v.sardy[0]; arready_s1 = v.sardy[1];
    rvalid_s0  = v.srv[0];   rvalid_s1  = v.srv[1];
    rlast_s0   = v.srl[0];   rlast_s1   = v.srl[1];
    rready_m0  = v.rrdy[0];  rready_m1  = v.rrdy[1];
  endtask

  function automatic logic [31:0] outs();
    return {19'd0, arready_m1, arready_m0, arvalid_s1, arvalid_s0, grant, sel,
            dflt_rvalid, dflt_rlast, busy, timeout};
  endfunction

  task automatic idle_inputs();
    rst = 1'b0;
    arvalid_m0 = 1'b0; arvalid_m1 = 1'b0; araddr_m0 = '0; araddr_m1 = '0;
    arlen_m0 = '0; arlen_m1 = '0; arready_s0 = 1'b0; arready_s1 = 1'b0;
    rvalid_s0 = 1'b0; rlast_s0 = 1'b0; rvalid_s1 = 1'b0; rlast_s1 = 1'b0;
    rready_m0 = 1'b0; rready_m1 = 1'b0;
  endtask

  localparam logic [12:0] Z = 13'b0;

  initial begin
    int unsigned beats;
    logic        seen;

    // Single beat to S0
    add("rst_state",   1, 2'b00, 32'h0,     0, 32'h0,      0, 2'b00, 2'b00, 2'b00, 2'b00, Z);
    add("m0_idle",     0, 2'b01, 32'h40,    0, 32'h0,      0, 2'b00, 2'b00, 2'b00, 2'b00, Z);
    add("m0_addr",     0, 2'b01, 32'h40,    0, 32'h0,      0, 2'b00, 2'b00, 2'b00, 2'b00, 13'b00_01_01_001_00_10);
    add("m0_addr_hs",  0, 2'b01, 32'h40,    0, 32'h0,      0, 2'b01, 2'b00, 2'b00, 2'b00, 13'b01_01_01_001_00_10);
    add("m0_rlast",    0, 2'b00, 32'h40,    0, 32'h0,      0, 2'b00, 2'b01, 2'b01, 2'b01, 13'b00_00_01_001_00_10);
    add("m0_done",     0, 2'b00, 32'h40,    0, 32'h0,      0, 2'b00, 2'b00, 2'b00, 2'b00, Z);
    // Round-robin ties
    add("rst2",        1, 2'b00, 32'h0,     0, 32'h0,      0, 2'b00, 2'b00, 2'b00, 2'b00, Z);
    add("tie_idle",    0, 2'b11, 32'h100,   0, 32'h1_0008, 0, 2'b00, 2'b00, 2'b00, 2'b00, Z);
    add("tie_m0_hs",   0, 2'b11, 32'h100,   0, 32'h1_0008, 0, 2'b01, 2'b00, 2'b00, 2'b00, 13'b01_01_01_001_00_10);
    add("tie_m0_data", 0, 2'b10, 32'h100,   0, 32'h1_0008, 0, 2'b00, 2'b01, 2'b01, 2'b01, 13'b00_00_01_001_00_10);
    add("tie_bubble",  0, 2'b10, 32'h100,   0, 32'h1_0008, 0, 2'b00, 2'b00, 2'b00, 2'b00, Z);
    add("tie_m1_hs",   0, 2'b10, 32'h100,   0, 32'h1_0008, 0, 2'b10, 2'b00, 2'b00, 2'b00, 13'b10_10_10_010_00_10);
    add("tie_m1_data", 0, 2'b00, 32'h100,   0, 32'h1_0008, 0, 2'b00, 2'b10, 2'b10, 2'b10, 13'b00_00_10_010_00_10);
    add("tie3_idle",   0, 2'b11, 32'h100,   0, 32'h1_0008, 0, 2'b00, 2'b00, 2'b00, 2'b00, Z);
    add("tie3_wait",   0, 2'b11, 32'h100,   0, 32'h1_0008, 0, 2'b00, 2'b00, 2'b00, 2'b00, 13'b00_01_01_001_00_10);
    add("tie3_hs",     0, 2'b11, 32'h100,   0, 32'h1_0008, 0, 2'b01, 2'b00, 2'b00, 2'b00, 13'b01_01_01_001_00_10);
    add("tie3_data",   0, 2'b10, 32'h100,   0, 32'h1_0008, 0, 2'b00, 2'b01, 2'b01, 2'b01, 13'b00_00_01_001_00_10);
    add("tie4_idle",   0, 2'b10, 32'h100,   0, 32'h1_0008, 0, 2'b00, 2'b00, 2'b00, 2'b00, Z);
    add("tie4_hs",     0, 2'b10, 32'h100,   0, 32'h1_0008, 0, 2'b10, 2'b00, 2'b00, 2'b00, 13'b10_10_10_010_00_10);
    add("tie4_data",   0, 2'b00, 32'h100,   0, 32'h1_0008, 0, 2'b00, 2'b10, 2'b10, 2'b10, 13'b00_00_10_010_00_10);
    // Default slave, ARLEN=3
    add("dflt_idle",   0, 2'b10, 32'h0,     0, 32'h2_0000, 3, 2'b00, 2'b00, 2'b00, 2'b00, Z);
    add("dflt_addr",   0, 2'b10, 32'h0,     0, 32'h2_0000, 3, 2'b00, 2'b00, 2'b00, 2'b00, 13'b10_00_10_100_00_10);
    add("dflt_b1",     0, 2'b00, 32'h0,     0, 32'h2_0000, 3, 2'b00, 2'b00, 2'b00, 2'b10, 13'b00_00_10_100_10_10);
    add("dflt_b2",     0, 2'b00, 32'h0,     0, 32'h2_0000, 3, 2'b00, 2'b00, 2'b00, 2'b10, 13'b00_00_10_100_10_10);
    add("dflt_stall",  0, 2'b00, 32'h0,     0, 32'h2_0000, 3, 2'b00, 2'b00, 2'b00, 2'b01, 13'b00_00_10_100_10_10);
    add("dflt_b3",     0, 2'b00, 32'h0,     0, 32'h2_0000, 3, 2'b00, 2'b00, 2'b00, 2'b10, 13'b00_00_10_100_10_10);
    add("dflt_b4_last",0, 2'b00, 32'h0,     0, 32'h2_0000, 3, 2'b00, 2'b00, 2'b00, 2'b10, 13'b00_00_10_100_11_10);
    add("dflt_done",   0, 2'b00, 32'h0,     0, 32'h2_0000, 3, 2'b00, 2'b00, 2'b00, 2'b00, Z);
    // S1 burst with toggling rready; M0 requests mid-burst
    add("bst_idle",    0, 2'b10, 32'h80,    0, 32'h1_0010, 3, 2'b00, 2'b00, 2'b00, 2'b00, Z);
    add("bst_hs",      0, 2'b10, 32'h80,    0, 32'h1_0010, 3, 2'b10, 2'b00, 2'b00, 2'b00, 13'b10_10_10_010_00_10);
    add("bst_r1",      0, 2'b00, 32'h80,    0, 32'h1_0010, 3, 2'b00, 2'b10, 2'b00, 2'b10, 13'b00_00_10_010_00_10);
    add("bst_r1n",     0, 2'b00, 32'h80,    0, 32'h1_0010, 3, 2'b00, 2'b10, 2'b00, 2'b00, 13'b00_00_10_010_00_10);
    add("bst_r2_m0req",0, 2'b01, 32'h80,    0, 32'h1_0010, 3, 2'b11, 2'b10, 2'b00, 2'b10, 13'b00_00_10_010_00_10);
    add("bst_r2n",     0, 2'b01, 32'h80,    0, 32'h1_0010, 3, 2'b11, 2'b10, 2'b00, 2'b00, 13'b00_00_10_010_00_10);
    add("bst_r3",      0, 2'b01, 32'h80,    0, 32'h1_0010, 3, 2'b11, 2'b10, 2'b00, 2'b10, 13'b00_00_10_010_00_10);
    add("bst_last_n",  0, 2'b01, 32'h80,    0, 32'h1_0010, 3, 2'b11, 2'b10, 2'b10, 2'b00, 13'b00_00_10_010_00_10);
    add("bst_last",    0, 2'b01, 32'h80,    0, 32'h1_0010, 3, 2'b11, 2'b10, 2'b10, 2'b10, 13'b00_00_10_010_00_10);
    add("bst_bubble",  0, 2'b01, 32'h80,    0, 32'h1_0010, 3, 2'b11, 2'b00, 2'b00, 2'b00, Z);
    add("bst_m0_hs",   0, 2'b01, 32'h80,    0, 32'h1_0010, 3, 2'b01, 2'b00, 2'b00, 2'b00, 13'b01_01_01_001_00_10);
    // Reset during DATA with M0 request pending
    add("rst_in_data", 1, 2'b01, 32'h40,    0, 32'h0,      0, 2'b00, 2'b00, 2'b00, 2'b00, 13'b00_00_01_001_00_10);
    add("rst_idle",    0, 2'b01, 32'h40,    0, 32'h0,      0, 2'b00, 2'b00, 2'b00, 2'b00, Z);
    add("rst_regrant", 0, 2'b01, 32'h40,    0, 32'h0,      0, 2'b00, 2'b00, 2'b00, 2'b00, 13'b00_01_01_001_00_10);
    add("rst_hs",      0, 2'b01, 32'h40,    0, 32'h0,      0, 2'b01, 2'b00, 2'b00, 2'b00, 13'b01_01_01_001_00_10);
    add("rst_data",    0, 2'b00, 32'h40,    0, 32'h0,      0, 2'b00, 2'b01, 2'b01, 2'b01, 13'b00_00_01_001_00_10);
    add("rst_done",    0, 2'b00, 32'h40,    0, 32'h0,      0, 2'b00, 2'b00, 2'b00, 2'b00, Z);
    // Decode boundaries
    add("s0_top_idle", 0, 2'b01, 32'hFFFC,  0, 32'h0,      0, 2'b00, 2'b00, 2'b00, 2'b00, Z);
    add("s0_top_hs",   0, 2'b01, 32'hFFFC,  0, 32'h0,      0, 2'b01, 2'b00, 2'b00, 2'b00, 13'b01_01_01_001_00_10);
    add("s0_top_data", 0, 2'b00, 32'hFFFC,  0, 32'h0,      0, 2'b00, 2'b01, 2'b01, 2'b01, 13'b00_00_01_001_00_10);
    add("s1_base_idle",0, 2'b01, 32'h1_0000,0, 32'h0,      0, 2'b00, 2'b00, 2'b00, 2'b00, Z);
    add("s1_wrong_rdy",0, 2'b01, 32'h1_0000,0, 32'h0,      0, 2'b01, 2'b00, 2'b00, 2'b00, 13'b00_10_01_010_00_10);
    add("s1_base_hs",  0, 2'b01, 32'h1_0000,0, 32'h0,      0, 2'b10, 2'b00, 2'b00, 2'b00, 13'b01_10_01_010_00_10);
    add("s1_wrong_rv", 0, 2'b00, 32'h1_0000,0, 32'h0,      0, 2'b00, 2'b01, 2'b01, 2'b01, 13'b00_00_01_010_00_10);
    add("s1_base_last",0, 2'b00, 32'h1_0000,0, 32'h0,      0, 2'b00, 2'b10, 2'b10, 2'b01, 13'b00_00_01_010_00_10);
    add("s1_done",     0, 2'b00, 32'h1_0000,0, 32'h0,      0, 2'b00, 2'b00, 2'b00, 2'b00, Z);
    add("dflt1_idle",  0, 2'b01, 32'hFFFF_FFF0, 0, 32'h0,  0, 2'b00, 2'b00, 2'b00, 2'b00, Z);
    add("dflt1_addr",  0, 2'b01, 32'hFFFF_FFF0, 0, 32'h0,  0, 2'b00, 2'b00, 2'b00, 2'b00, 13'b01_00_01_100_00_10);
    add("dflt1_last",  0, 2'b00, 32'hFFFF_FFF0, 0, 32'h0,  0, 2'b00, 2'b00, 2'b00, 2'b01, 13'b00_00_01_100_11_10);
    add("dflt1_done",  0, 2'b00, 32'hFFFF_FFF0, 0, 32'h0,  0, 2'b00, 2'b00, 2'b00, 2'b00, Z);

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);

    for (int unsigned i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk(tbl[i].name, outs(), {19'd0, tbl[i].exp});
    end

    // Default-slave burst with ARLEN=15: 16 beats, RLAST only on the last
    @(negedge clk);
    idle_inputs();
    arvalid_m0 = 1'b1; araddr_m0 = 32'h3000_0000; arlen_m0 = 4'd15;
    @(negedge clk);
    #1;
    chk("l15_arready", {31'd0, arready_m0}, 32'd1);
    chk("l15_sel", {29'd0, sel}, 32'd4);
    arvalid_m0 = 1'b0; rready_m0 = 1'b1;
    beats = 0;
    seen  = 1'b0;
    for (int unsigned n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      #1;
      if (dflt_rvalid) beats++;
      if (dflt_rlast) seen = 1'b1;
    end
    chk("l15_rlast_seen", {31'd0, seen}, 32'd1);
    chk("l15_beats", beats, 32'd16);
    @(negedge clk);
    #1;
    chk("l15_busy_after", {31'd0, busy}, 32'd0);
    rready_m0 = 1'b0;

`ifdef AXI_ARB_TIMEOUT_EN
    begin
      int unsigned cyc;
      logic        fired;
      @(negedge clk);
      idle_inputs();
      arvalid_m0 = 1'b1; araddr_m0 = 32'h40;
      @(negedge clk);
      arready_s0 = 1'b1;
      @(negedge clk);
      arvalid_m0 = 1'b0; arready_s0 = 1'b0;
      cyc   = 0;
      fired = 1'b0;
      for (int unsigned n = 1; n <= 20 && !fired; n++) begin
        #1;
        if (timeout) begin
          fired = 1'b1;
          cyc   = n;
        end else begin
          @(negedge clk);
        end
      end
      chk("wd_fired", {31'd0, fired}, 32'd1);
      chk("wd_cycle", cyc, 32'd8);
      @(negedge clk);
      #1;
      chk("wd_busy_after", {31'd0, busy}, 32'd0);
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
